menu_sequencer: RTL
===================

// Module: menu_sequencer
// PURPOSE
//  Top-level game-flow FSM: MENU -> COUNTDOWN -> PLAY -> OVER -> MENU. Conditions the mode/start buttons
//  and times the per-second countdown. Drives the menu overlay renderer's menu_active, countdown_active,
//  countdown_value and game_mode_1p inputs, and gates the game core via play_active/game_init.
// PARAMETERS
//  TICKS_PER_SEC    25_000_000  pixel_clk cycles per countdown step
//  COUNT_START      3           first countdown value shown (range 1..255)
//  DEBOUNCE_CYCLES  250_000     stable cycles required per button edge (MENU_DEBOUNCE_EN only)
// PORTS
//  pixel_clk         in   1  25 MHz pixel clock, all logic rising-edge
//  reset_n           in   1  asynchronous, active-low reset
//  btn_mode          in   1  raw async button: toggle 1P/2P in MENU
//  btn_start         in   1  raw async button: start game / leave OVER
//  game_over         in   1  level from game core, sampled in PLAY only
//  menu_active       out  1  high in MENU
//  countdown_active  out  1  high in COUNTDOWN
//  countdown_value   out  8  current count, COUNT_START..0 (0 = "START" text)
//  game_mode_1p      out  1  1 = one player, 0 = two players
//  play_active       out  1  high in PLAY
//  game_init         out  1  one-cycle pulse on COUNTDOWN->PLAY transition
// BEHAVIOUR
//  - All outputs registered. Reset values: menu_active=1, countdown_active=0, countdown_value=COUNT_START,
//    game_mode_1p=1, play_active=0, game_init=0; state=MENU, prescaler=0.
//  - Buttons: 2-FF synchronizer each, then rising-edge detect -> single-cycle *_evt. Raw press to evt
//    asserted: 3 cycles. Held button yields one evt only.
//  - Output flags change on the same clock edge as the state register (decoded from next state).
//  - MENU: mode_evt toggles game_mode_1p. start_evt -> COUNTDOWN; countdown_value<=COUNT_START, prescaler<=0.
//    mode_evt and start_evt same cycle: start wins, mode NOT toggled.
//  - COUNTDOWN: prescaler counts 0..TICKS_PER_SEC-1, wraps to 0. At wrap: if countdown_value>0 decrement;
//    if countdown_value==0 -> PLAY, game_init=1 for that one cycle. Total COUNTDOWN dwell =
//    (COUNT_START+1)*TICKS_PER_SEC cycles. Buttons and game_over ignored. game_mode_1p frozen.
//  - PLAY: game_over==1 -> OVER. Buttons ignored. countdown_value holds 0.
//  - OVER: all four flags low. start_evt -> MENU; countdown_value<=COUNT_START; game_mode_1p retained.
//    mode_evt ignored. game_over level ignored (no re-trigger).
//  - Prescaler width $clog2(TICKS_PER_SEC), only advances in COUNTDOWN, cleared elsewhere.
//  - Exactly one of menu_active/countdown_active/play_active high outside OVER; never two at once.
//  - Reset asserted mid-operation (any state): immediate return to reset values; no game_init emitted.
//  - Illegal state encoding: recover to MENU next cycle with reset output values.
// CONFIGURATION
//  MENU_DEBOUNCE_EN defined: per-button counter between synchronizer and edge detect; debounced level
//    updates only after synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles;
//    any bounce restarts count. Press-to-evt latency = DEBOUNCE_CYCLES+3 cycles. Debounced level resets 0.
//  MENU_DEBOUNCE_EN undefined: no counter, edge detect directly on synchronized level, 3-cycle latency;
//    DEBOUNCE_CYCLES unused.
// TESTING  (TICKS_PER_SEC=4, COUNT_START=3, DEBOUNCE_CYCLES=5)
//  1 Reset: release reset_n -> menu_active=1, game_mode_1p=1, countdown_value=3, others 0; hold 20 cycles, no change.
//  2 Mode toggle: two separated btn_mode pulses (held 10 cycles each) -> game_mode_1p 1->0->1, one toggle per press.
//  3 Countdown: btn_start in MENU -> countdown_active=1; value 3,2,1,0 each 4 cycles; after 16 cycles play_active=1,
//    game_init high exactly 1 cycle, countdown_active=0.
//  4 Game flow: game_over=1 in PLAY -> next edge all flags 0; btn_start -> menu_active=1, value=3, mode retained.
//  5 Conflicts: btn_mode+btn_start same cycle in MENU -> COUNTDOWN, mode unchanged; btn_mode/game_over during
//    COUNTDOWN -> no effect; reset_n low at value=1 -> immediate reset values, no game_init.
//  6 MENU_DEBOUNCE_EN: btn_start bouncing 1,0,1 (1-cycle glitches) then stable -> single start_evt exactly
//    DEBOUNCE_CYCLES+3 cycles after last edge; 3-cycle glitch alone -> no evt. Without macro: glitch -> evt.

Source files
------------

// File: rtl/menu_sequencer.sv
// -----------------------------------------------------------------------------
// menu_sequencer
//   Top-level game-flow sequencer: MENU -> COUNTDOWN -> PLAY -> OVER -> MENU.
//   Conditions the two raw push buttons (mode, start), times the per-second
//   countdown and drives the menu overlay renderer and the game core gates.
//
// Build option
//   MENU_DEBOUNCE_EN : when defined, each button gets a debounce counter between
//                      its synchronizer and its edge detector (press-to-event
//                      latency DEBOUNCE_CYCLES+3). When undefined, the edge
//                      detector sees the synchronized level directly (latency 3)
//                      and DEBOUNCE_CYCLES has no effect.
//
// Parameters
//   TICKS_PER_SEC   pixel_clk cycles per countdown step
//   COUNT_START     first countdown value shown (1..255)
//   DEBOUNCE_CYCLES stable cycles required per button edge (debounce build only)
//
// Ports
//   pixel_clk         in   1  pixel clock, all logic on rising edge
//   reset_n           in   1  asynchronous active-low reset
//   btn_mode          in   1  raw async button, toggles 1P/2P in MENU
//   btn_start         in   1  raw async button, starts game / leaves OVER
//   game_over         in   1  level from game core, honoured in PLAY only
//   menu_active       out  1  high in MENU
//   countdown_active  out  1  high in COUNTDOWN
//   countdown_value   out  8  current count COUNT_START..0 (0 = "START")
//   game_mode_1p      out  1  1 = one player, 0 = two players
//   play_active       out  1  high in PLAY
//   game_init         out  1  one-cycle pulse on COUNTDOWN->PLAY
// -----------------------------------------------------------------------------
module menu_sequencer #(
  parameter int unsigned TICKS_PER_SEC   = 25_000_000,
  parameter int unsigned COUNT_START     = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 250_000
) (
  input  logic       pixel_clk,
  input  logic       reset_n,
  input  logic       btn_mode,
  input  logic       btn_start,
  input  logic       game_over,
  output logic       menu_active,
  output logic       countdown_active,
  output logic [7:0] countdown_value,
  output logic       game_mode_1p,
  output logic       play_active,
  output logic       game_init
);

  localparam int unsigned   PW         = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [PW-1:0] PRESC_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
  localparam logic [7:0]    CNT_INIT   = 8'(COUNT_START);

  // 3-bit encoding leaves four unused codes; any of them recovers to MENU.
  typedef enum logic [2:0] {
    S_MENU      = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_PLAY      = 3'd2,
    S_OVER      = 3'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Button conditioning. Bit 0 = mode, bit 1 = start.
  // ---------------------------------------------------------------------------
  logic [1:0] w_btn_raw;
  logic [1:0] w_level;
  logic [1:0] r_sync0;
  logic [1:0] r_sync1;
  logic [1:0] r_edge_prev;
  logic [1:0] r_evt;
  logic       w_mode_evt;
  logic       w_start_evt;

  assign w_btn_raw = {btn_start, btn_mode};

  // Two-flop synchronizer for both raw buttons.
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync0 <= 2'b00;
      r_sync1 <= 2'b00;
    end else begin
      r_sync0 <= w_btn_raw;
      r_sync1 <= r_sync0;
    end
  end

`ifdef MENU_DEBOUNCE_EN
  localparam int unsigned   DB_LIMIT = (DEBOUNCE_CYCLES > 1) ? DEBOUNCE_CYCLES : 1;
  localparam int unsigned   DW       = (DB_LIMIT > 1) ? $clog2(DB_LIMIT) : 1;
  localparam logic [DW-1:0] DB_LAST  = DW'(DB_LIMIT - 1);
  localparam logic [DW-1:0] DB_ZERO  = {DW{1'b0}};
  localparam logic [DW-1:0] DB_ONE   = DW'(1);

  logic [DW-1:0] r_db_cnt [2];
  logic [1:0]    r_db_level;

  // Debounce: the level follows the synchronized input only after it has
  // disagreed for DB_LIMIT consecutive cycles; any agreement restarts the run.
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_db_level <= 2'b00;
      for (int b = 0; b < 2; b++) begin
        r_db_cnt[b] <= DB_ZERO;
      end
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (r_sync1[b] != r_db_level[b]) begin
          if (r_db_cnt[b] == DB_LAST) begin
            r_db_level[b] <= r_sync1[b];
            r_db_cnt[b]   <= DB_ZERO;
          end else begin
            r_db_cnt[b]   <= r_db_cnt[b] + DB_ONE;
          end
        end else begin
          r_db_cnt[b] <= DB_ZERO;
        end
      end
    end
  end

  assign w_level = r_db_level;
`else
  // Debounce disabled: the threshold parameter is accepted but not used.
  if (DEBOUNCE_CYCLES == 0) begin : g_debounce_unused
  end

  assign w_level = r_sync1;
`endif

  // Rising-edge detect; a held button produces a single registered event.
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_edge_prev <= 2'b00;
      r_evt       <= 2'b00;
    end else begin
      r_edge_prev <= w_level;
      r_evt       <= w_level & ~r_edge_prev;
    end
  end

  assign w_mode_evt  = r_evt[0];
  assign w_start_evt = r_evt[1];

  // ---------------------------------------------------------------------------
  // Game-flow FSM
  // ---------------------------------------------------------------------------
  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_presc;
  logic [PW-1:0] w_presc_nxt;
  logic [7:0]    r_cnt;
  logic [7:0]    w_cnt_nxt;
  logic          r_mode;
  logic          w_mode_nxt;
  logic          w_init_nxt;
  logic          r_menu;
  logic          r_cd;
  logic          r_play;
  logic          r_init;

  // Next-state, prescaler, count and mode decode.
  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = PRESC_ZERO;
    w_cnt_nxt   = r_cnt;
    w_mode_nxt  = r_mode;
    w_init_nxt  = 1'b0;
    case (r_state)
      S_MENU: begin
        // Start takes priority over a simultaneous mode press.
        if (w_start_evt) begin
          w_state_nxt = S_COUNTDOWN;
          w_cnt_nxt   = CNT_INIT;
        end else if (w_mode_evt) begin
          w_mode_nxt  = ~r_mode;
        end else begin
          w_mode_nxt  = r_mode;
        end
      end
      S_COUNTDOWN: begin
        if (r_presc == PRESC_LAST) begin
          w_presc_nxt = PRESC_ZERO;
          if (r_cnt != 8'd0) begin
            w_cnt_nxt   = r_cnt - 8'd1;
          end else begin
            w_state_nxt = S_PLAY;
            w_init_nxt  = 1'b1;
          end
        end else begin
          w_presc_nxt = r_presc + PRESC_ONE;
        end
      end
      S_PLAY: begin
        w_cnt_nxt = 8'd0;
        if (game_over) begin
          w_state_nxt = S_OVER;
        end else begin
          w_state_nxt = S_PLAY;
        end
      end
      S_OVER: begin
        if (w_start_evt) begin
          w_state_nxt = S_MENU;
          w_cnt_nxt   = CNT_INIT;
        end else begin
          w_state_nxt = S_OVER;
        end
      end
      default: begin
        // Unused encoding: return to MENU with reset output values.
        w_state_nxt = S_MENU;
        w_cnt_nxt   = CNT_INIT;
        w_mode_nxt  = 1'b1;
      end
    endcase
  end

  // State, counters and output flags; flags are decoded from the next state
  // so they change on the same edge as the state register.
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_MENU;
      r_presc <= PRESC_ZERO;
      r_cnt   <= CNT_INIT;
      r_mode  <= 1'b1;
      r_menu  <= 1'b1;
      r_cd    <= 1'b0;
      r_play  <= 1'b0;
      r_init  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_presc <= w_presc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_mode  <= w_mode_nxt;
      r_menu  <= (w_state_nxt == S_MENU);
      r_cd    <= (w_state_nxt == S_COUNTDOWN);
      r_play  <= (w_state_nxt == S_PLAY);
      r_init  <= w_init_nxt;
    end
  end

  assign menu_active      = r_menu;
  assign countdown_active = r_cd;
  assign countdown_value  = r_cnt;
  assign game_mode_1p     = r_mode;
  assign play_active      = r_play;
  assign game_init        = r_init;

endmodule
